// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: merges buffered CPU pixel writes and an optional full-screen fill into one framebuffer write port.
// Optional fill engine is built only when VGA_FB_CLEAR_EN is defined.
// Ports:
//   clock_50, reset_n        - clock, asynchronous active-low reset
//   cpu_data/cpu_cs/cpu_we   - CPU pixel write {line[13:8], col[7:1], pixel[0]}
//   cpu_ready, cpu_drop      - write accepted / out-of-range write discarded
//   clr_start, clr_value     - fill request and fill pixel value
//   clr_busy, clr_done       - fill in progress / fill finished pulse
//   out_data, out_cs, out_we - registered framebuffer write
module vga_fb_scheduler (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic [31:0] cpu_data,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  output logic        cpu_ready,
  output logic        cpu_drop,
  input  logic        clr_start,
  input  logic        clr_value,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [31:0] out_data,
  output logic        out_cs,
  output logic        out_we
);
  logic [13:0] r_mem [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_cnt;
  logic        r_rdy, r_drop, r_cs;
  logic [13:0] r_out;
  logic        w_accept, w_oor, w_push, w_fifo_req, w_gnt_fifo, w_gnt_fill, w_unused;
  logic [13:0] w_head, w_fill_word;

  assign w_unused   = &{1'b0, cpu_data[31:14]};
  assign cpu_ready  = r_rdy & (r_cnt < 3'd4);
  assign w_accept   = cpu_cs & cpu_we & cpu_ready;
  assign w_oor      = (cpu_data[7:1] > 7'd79) | (cpu_data[13:8] > 6'd59);
  assign w_push     = w_accept & ~w_oor;
  // An incoming write counts as a pending FIFO head so an empty FIFO is bypassed
  assign w_fifo_req = (r_cnt != 3'd0) | w_push;
  assign w_head     = (r_cnt != 3'd0) ? r_mem[r_rp] : cpu_data[13:0];
  assign cpu_drop   = r_drop;
  assign out_data   = {18'd0, r_out};
  assign out_cs     = r_cs;
  assign out_we     = r_cs;

`ifdef VGA_FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state, w_state_nxt;
  logic [5:0] r_line;
  logic [6:0] r_col;
  logic       r_val, r_rr_fill, w_fill_req, w_last;

  assign w_fill_req  = (r_state == RUN);
  assign w_last      = (r_line == 6'd59) & (r_col == 7'd79);
  assign w_gnt_fifo  = w_fifo_req & (~w_fill_req | ~r_rr_fill);
  assign w_gnt_fill  = w_fill_req & ~w_gnt_fifo;
  assign w_fill_word = {r_line, r_col, r_val};

  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    clr_busy    = (r_state != IDLE);
    clr_done    = (r_state == DONE);
    case (r_state)
      IDLE:    w_state_nxt = clr_start ? RUN : IDLE;
      RUN:     w_state_nxt = (w_gnt_fill & w_last) ? DONE : RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) begin
      r_line    <= '0;
      r_col     <= '0;
      r_val     <= 1'b0;
      r_rr_fill <= 1'b0;
    end else begin
      if (r_state == IDLE && clr_start) begin
        r_line <= '0;
        r_col  <= '0;
        r_val  <= clr_value;
      end else if (w_gnt_fill) begin
        r_col  <= (r_col == 7'd79) ? 7'd0 : r_col + 7'd1;
        r_line <= (r_col == 7'd79) ? r_line + 6'd1 : r_line;
      end
      // Pointer only moves on contention: the loser of this edge wins the next one
      if (w_fifo_req & w_fill_req) r_rr_fill <= w_gnt_fifo;
    end
`else
  logic w_unused_clr;
  assign w_unused_clr = &{1'b0, clr_start, clr_value};
  assign w_gnt_fifo   = w_fifo_req;
  assign w_gnt_fill   = 1'b0;
  assign w_fill_word  = '0;
  assign clr_busy     = 1'b0;
  assign clr_done     = 1'b0;
`endif

  always_ff @(posedge clock_50)
    if (w_push) r_mem[r_wp] <= cpu_data[13:0];

  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
      r_drop <= 1'b0;
      r_cs   <= 1'b0;
      r_out  <= '0;
    end else begin
      r_rdy  <= 1'b1;
      r_drop <= w_accept & w_oor;
      r_cs   <= w_gnt_fifo | w_gnt_fill;
      if (w_gnt_fifo)      r_out <= w_head;
      else if (w_gnt_fill) r_out <= w_fill_word;
      if (w_push)     r_wp <= r_wp + 2'd1;
      if (w_gnt_fifo) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'd0, w_push} - {2'd0, w_gnt_fifo};
    end
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed vector bench for vga_fb_scheduler (fill cases when VGA_FB_CLEAR_EN is defined).
module tb_vga_fb_scheduler;
  logic        clock_50 = 1'b0, reset_n = 1'b0;
  logic [31:0] cpu_data = '0;
  logic        cpu_cs = 1'b0, cpu_we = 1'b0, clr_start = 1'b0, clr_value = 1'b0;
  logic        cpu_ready, cpu_drop, clr_busy, clr_done, out_cs, out_we;
  logic [31:0] out_data;

  vga_fb_scheduler dut (
    .clock_50(clock_50), .reset_n(reset_n), .cpu_data(cpu_data), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready), .cpu_drop(cpu_drop), .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done), .out_data(out_data), .out_cs(out_cs), .out_we(out_we)
  );

  always #10 clock_50 = ~clock_50;

  int checks = 0, failures = 0, cyc = 0, cswe_err = 0, n_done = 0;
  logic [31:0] q_w[$];
  int          q_t[$];
  logic [31:0] cw[$];

  always @(posedge clock_50) cyc++;
  always @(negedge clock_50) begin
    if (out_cs) begin
      q_w.push_back(out_data);
      q_t.push_back(cyc);
    end
    if (out_cs !== out_we) cswe_err++;
    if (clr_done) n_done++;
  end

  initial begin
    #4000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clock_50);
    reset_n = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; clr_start = 1'b0;
    #1;
    chk("rst_out_cs", out_cs, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_drop", cpu_drop, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    @(negedge clock_50);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", cpu_ready, 0);
    @(posedge clock_50);
    #1 chk("ready_first_edge", cpu_ready, 1);
    q_w.delete(); q_t.delete(); n_done = 0;
  endtask

  typedef struct {
    logic        cs, we;
    logic [31:0] d;
    logic        e_cs;
    logic [31:0] e_data;
    logic        e_drop;
  } vec_t;
  vec_t vecs[10];

`ifdef VGA_FB_CLEAR_EN
  task automatic start_fill;
    @(negedge clock_50);
    clr_value = 1'b1; clr_start = 1'b1;
    @(negedge clock_50);
    clr_start = 1'b0;
    chk("fill_busy_start", clr_busy, 1);
  endtask

  task automatic wait_done;
    int t = 0;
    while (!clr_done && t < 6000) begin
      @(negedge clock_50);
      t++;
    end
    chk("fill_done_seen", clr_done, 1);
    chk("fill_busy_in_done", clr_busy, 1);
    @(negedge clock_50);
    chk("fill_done_pulse_end", clr_done, 0);
    chk("fill_busy_end", clr_busy, 0);
  endtask

  task automatic analyze(output int nfill, output int fbad, output int span, output int adj);
    logic [31:0] e;
    nfill = 0; fbad = 0; adj = 0;
    cw.delete();
    span = (q_t.size() > 0) ? q_t[q_t.size()-1] - q_t[0] + 1 : 0;
    foreach (q_w[i]) begin
      if (q_w[i][0]) begin
        e = {18'd0, 6'(nfill / 80), 7'(nfill % 80), 1'b1};
        if (q_w[i] !== e) fbad++;
        nfill++;
      end else begin
        cw.push_back(q_w[i]);
        if (i > 0 && !q_w[i-1][0]) adj++;
      end
    end
  endtask

  function automatic logic [31:0] dval(input int k);
    return {18'd0, 6'(k + 1), 7'(k * 3), 1'b0};
  endfunction
`endif

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0A0F, 1'b1, 32'h0000_0A0F, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_3C01, 1'b0, 32'h0000_0A0F, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_00A0, 1'b0, 32'h0000_0A0F, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0101, 1'b0, 32'h0000_0A0F, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0101, 1'b0, 32'h0000_0A0F, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_3B9F, 1'b1, 32'h0000_3B9F, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_C203, 1'b1, 32'h0000_0203, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_3FFF, 1'b0, 32'h0000_0203, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_009E, 1'b1, 32'h0000_009E, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 32'h0000_3B00, 1'b1, 32'h0000_3B00, 1'b0};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clock_50);
      cpu_cs = vecs[i].cs; cpu_we = vecs[i].we; cpu_data = vecs[i].d;
      @(negedge clock_50);
      chk($sformatf("v%0d_out_cs", i), out_cs, vecs[i].e_cs);
      chk($sformatf("v%0d_out_we", i), out_we, vecs[i].e_cs);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_drop", i), cpu_drop, vecs[i].e_drop);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      @(negedge clock_50);
      chk($sformatf("v%0d_idle_cs", i), out_cs, 0);
      chk($sformatf("v%0d_idle_drop", i), cpu_drop, 0);
      chk($sformatf("v%0d_idle_hold", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_ready", i), cpu_ready, 1);
    end

    @(negedge clock_50);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_data = 32'h0000_0102;
    @(negedge clock_50);
    cpu_data = 32'h0000_0205;
    chk("b2b_0_cs", out_cs, 1);
    chk("b2b_0_data", out_data, 32'h0000_0102);
    @(negedge clock_50);
    cpu_data = 32'h0000_0306;
    chk("b2b_1_cs", out_cs, 1);
    chk("b2b_1_data", out_data, 32'h0000_0205);
    @(negedge clock_50);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    chk("b2b_2_cs", out_cs, 1);
    chk("b2b_2_data", out_data, 32'h0000_0306);
    @(negedge clock_50);
    chk("b2b_idle_cs", out_cs, 0);

`ifdef VGA_FB_CLEAR_EN
    begin
      int nfill, fbad, span, adj, k, first_low, guard, sz;
      logic [31:0] cexp[3];
      cexp[0] = 32'h0000_0A0E; cexp[1] = 32'h0000_1402; cexp[2] = 32'h0000_3B9E;

      do_reset();
      start_fill();
      wait_done();
      analyze(nfill, fbad, span, adj);
      chk("fill_count", nfill, 4800);
      chk("fill_words_bad", fbad, 0);
      chk("fill_span", span, 4800);
      chk("fill_first", q_w.size() > 0 ? q_w[0] : 32'hx, 32'h0000_0001);
      chk("fill_last", q_w.size() > 0 ? q_w[q_w.size()-1] : 32'hx, 32'h0000_3B9F);
      chk("fill_done_pulses", n_done, 1);

      do_reset();
      start_fill();
      for (int i = 0; i < 3; i++) begin
        repeat (20) @(negedge clock_50);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_data = cexp[i];
        @(negedge clock_50);
        cpu_cs = 1'b0; cpu_we = 1'b0;
      end
      wait_done();
      analyze(nfill, fbad, span, adj);
      chk("cont_fill_count", nfill, 4800);
      chk("cont_fill_bad", fbad, 0);
      chk("cont_span", span, 4803);
      chk("cont_adjacent_cpu", adj, 0);
      chk("cont_cpu_count", cw.size(), 3);
      for (int i = 0; i < 3; i++)
        chk($sformatf("cont_cpu%0d", i), i < cw.size() ? cw[i] : 32'hx, cexp[i]);

      do_reset();
      start_fill();
      repeat (5) @(negedge clock_50);
      k = 0; first_low = -1; guard = 0;
      while (k < 10 && guard < 200) begin
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_data = dval(k);
        if (cpu_ready) k++;
        else if (first_low < 0) first_low = k;
        @(negedge clock_50);
        guard++;
      end
      cpu_cs = 1'b0; cpu_we = 1'b0;
      chk("full_accepted", k, 10);
      chk("full_ready_low_at", first_low, 8);
      wait_done();
      analyze(nfill, fbad, span, adj);
      chk("full_fill_count", nfill, 4800);
      chk("full_fill_bad", fbad, 0);
      chk("full_span", span, 4810);
      chk("full_cpu_count", cw.size(), 10);
      for (int i = 0; i < 10; i++)
        chk($sformatf("full_cpu%0d", i), i < cw.size() ? cw[i] : 32'hx, dval(i));

      do_reset();
      start_fill();
      guard = 0;
      while (q_w.size() < 100 && guard < 500) begin
        @(negedge clock_50);
        guard++;
      end
      chk("mid_reached_100", q_w.size() >= 100, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_out_cs", out_cs, 0);
      chk("mid_clr_busy", clr_busy, 0);
      @(negedge clock_50);
      reset_n = 1'b1;
      sz = q_w.size();
      repeat (50) @(negedge clock_50);
      chk("mid_no_writes_after", q_w.size(), sz);
      chk("mid_busy_after", clr_busy, 0);
    end
`else
    q_w.delete(); n_done = 0;
    @(negedge clock_50);
    clr_value = 1'b1; clr_start = 1'b1;
    @(negedge clock_50);
    clr_start = 1'b0;
    chk("noclr_busy_now", clr_busy, 0);
    repeat (20) @(negedge clock_50);
    chk("noclr_busy", clr_busy, 0);
    chk("noclr_done", n_done, 0);
    chk("noclr_writes", q_w.size(), 0);
`endif

    chk("cs_we_equal", cswe_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
